// File: rtl/mux_scan.sv
// mux_scan -- registered N:1 channel selector with an output valid/ready
// handshake and an auto-scan mode that round-robins over an enable mask.
//
// Sits between a bank of sampled status/data lanes and a single serial
// consumer such as a logger or debug port.
//
// Parameters:
//   WIDTH     data width per channel
//   CHANNELS  number of input channels (2..256)
//   SEL_W     select / channel-index width, derived from CHANNELS
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in         flattened channels, channel k = in[k*WIDTH +: WIDTH]
//   sel        channel select used in direct mode
//   mode       0 = direct, 1 = scan
//   mask       per-channel enable used in scan mode
//   out        registered sample data
//   out_ch     index of the channel held in out
//   out_valid  out/out_ch hold a sample
//   out_ready  consumer accepts the sample
//   out_par    (MUX_SCAN_PARITY_EN only) XOR reduction of the held sample
//
// Optional feature macro: MUX_SCAN_PARITY_EN adds the out_par output.

module mux_scan #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 16,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      mode,
  input  logic [CHANNELS-1:0]       mask,
  output logic [WIDTH-1:0]          out,
  output logic [SEL_W-1:0]          out_ch,
  output logic                      out_valid,
  input  logic                      out_ready
`ifdef MUX_SCAN_PARITY_EN
  ,
  output logic                      out_par
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIRECT,
    S_SCAN
  } state_t;

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_data;
  logic [SEL_W-1:0] r_ch;
  logic             r_valid;
  logic [SEL_W-1:0] r_ptr;
`ifdef MUX_SCAN_PARITY_EN
  logic             r_par;
`endif

  logic [WIDTH-1:0] w_chan [CHANNELS];
  logic             w_lo;
  logic [SEL_W-1:0] w_dirIdx;
  logic             w_hiFound;
  logic [SEL_W-1:0] w_hiIdx;
  logic             w_loFound;
  logic [SEL_W-1:0] w_loIdx;
  logic             w_scanFound;
  logic [SEL_W-1:0] w_scanIdx;
  logic [SEL_W-1:0] w_nextPtr;
  logic             w_loadEn;
  logic [SEL_W-1:0] w_loadIdx;
  logic [WIDTH-1:0] w_loadData;

  // Unpack the flattened input bus into one entry per channel.
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      w_chan[k] = in[k*WIDTH +: WIDTH];
    end
  end

  // A new sample may be taken whenever the output slot is empty or is
  // being consumed on this edge.
  assign w_lo = !r_valid || out_ready;

  // Out-of-range selects only exist when CHANNELS is not a power of two;
  // they fall back to the last channel.
  generate
    if ((1 << SEL_W) == CHANNELS) begin : g_noClamp
      assign w_dirIdx = sel;
    end else begin : g_clamp
      assign w_dirIdx = (32'(sel) >= 32'(CHANNELS)) ? LAST_CH : sel;
    end
  endgenerate

  // Round-robin search. Scanning downward leaves the lowest set index in
  // each result: hi* covers indices at or above the pointer, lo* covers the
  // whole mask and is used when the search has to wrap to index 0.
  always_comb begin
    w_hiFound = 1'b0;
    w_hiIdx   = '0;
    w_loFound = 1'b0;
    w_loIdx   = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (mask[i]) begin
        w_loFound = 1'b1;
        w_loIdx   = SEL_W'(i);
        if (i >= int'(r_ptr)) begin
          w_hiFound = 1'b1;
          w_hiIdx   = SEL_W'(i);
        end
      end
    end
  end

  assign w_scanFound = w_loFound;
  assign w_scanIdx   = w_hiFound ? w_hiIdx : w_loIdx;
  assign w_nextPtr   = (w_scanIdx == LAST_CH) ? '0 : w_scanIdx + 1'b1;

  // A mode change at a load opportunity spends that opportunity switching,
  // so loads only happen when the mode input agrees with the current state.
  assign w_loadEn   = w_lo && (((r_state == S_DIRECT) && !mode) ||
                               ((r_state == S_SCAN) && mode && w_scanFound));
  assign w_loadIdx  = (r_state == S_SCAN) ? w_scanIdx : w_dirIdx;
  assign w_loadData = w_chan[w_loadIdx];

  // Control FSM and output registers. Nothing moves unless there is a load
  // opportunity, which keeps a stalled sample frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_data  <= '0;
      r_ch    <= '0;
      r_valid <= 1'b0;
      r_ptr   <= '0;
`ifdef MUX_SCAN_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      if (w_loadEn) begin
        r_data  <= w_loadData;
        r_ch    <= w_loadIdx;
        r_valid <= 1'b1;
`ifdef MUX_SCAN_PARITY_EN
        r_par   <= ^w_loadData;
`endif
      end
      if (w_lo) begin
        case (r_state)
          S_IDLE: begin
            r_state <= mode ? S_SCAN : S_DIRECT;
            r_ptr   <= '0;
          end
          S_DIRECT: begin
            if (mode) begin
              r_state <= S_SCAN;
              r_ptr   <= '0;
              r_valid <= 1'b0;
            end
          end
          S_SCAN: begin
            if (!mode) begin
              r_state <= S_DIRECT;
              r_valid <= 1'b0;
            end else if (w_scanFound) begin
              r_ptr   <= w_nextPtr;
            end else begin
              // Empty mask: drop valid but keep the last data and index.
              r_valid <= 1'b0;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign out       = r_data;
  assign out_ch    = r_ch;
  assign out_valid = r_valid;
`ifdef MUX_SCAN_PARITY_EN
  assign out_par   = r_par;
`endif

endmodule

// File: tb/tb_mux_scan.sv
// tb_mux_scan -- self-checking bench for mux_scan.
//
// Instance dut: WIDTH=8, CHANNELS=16, compared every cycle against a
// behavioural model and against fixed values at the directed scenarios.
// Instance dut12: WIDTH=1, CHANNELS=12, exercises the out-of-range select
// fallback to the last channel.
//
// MUX_SCAN_PARITY_EN, when defined, also connects and checks out_par.

module tb_mux_scan;

  localparam int W  = 8;
  localparam int CH = 16;

  localparam int PH_IDLE   = 0;
  localparam int PH_DIRECT = 1;
  localparam int PH_SCAN   = 2;

  logic            clk = 1'b0;
  logic            rst;

  logic [CH*W-1:0] dIn;
  logic [3:0]      dSel;
  logic            dMode;
  logic [CH-1:0]   dMask;
  logic            dReady;
  logic [W-1:0]    dOut;
  logic [3:0]      dCh;
  logic            dValid;

  logic [11:0]     cIn;
  logic [3:0]      cSel;
  logic            cMode;
  logic [11:0]     cMask;
  logic            cReady;
  logic [0:0]      cOut;
  logic [3:0]      cCh;
  logic            cValid;

`ifdef MUX_SCAN_PARITY_EN
  logic            dPar;
  logic            cPar;
`endif

  int              mPhase;
  logic [W-1:0]    mOut;
  logic [3:0]      mCh;
  logic            mValid;
  int              mPtr;
  logic            mPar;

  int              nChecks;
  int              nFail;

  always #5 clk = ~clk;

  mux_scan #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (dIn),
    .sel       (dSel),
    .mode      (dMode),
    .mask      (dMask),
    .out       (dOut),
    .out_ch    (dCh),
    .out_valid (dValid),
    .out_ready (dReady)
`ifdef MUX_SCAN_PARITY_EN
    ,
    .out_par   (dPar)
`endif
  );

  mux_scan #(.WIDTH(1), .CHANNELS(12)) dut12 (
    .clk       (clk),
    .rst       (rst),
    .in        (cIn),
    .sel       (cSel),
    .mode      (cMode),
    .mask      (cMask),
    .out       (cOut),
    .out_ch    (cCh),
    .out_valid (cValid),
    .out_ready (cReady)
`ifdef MUX_SCAN_PARITY_EN
    ,
    .out_par   (cPar)
`endif
  );

  // Behavioural reference: one call per rising edge, using the inputs that
  // were stable before that edge.
  task automatic modelStep();
    int found;
    if (rst) begin
      mPhase = PH_IDLE;
      mOut   = '0;
      mCh    = '0;
      mValid = 1'b0;
      mPtr   = 0;
      mPar   = 1'b0;
    end else if (!mValid || dReady) begin
      if (mPhase == PH_IDLE) begin
        mPhase = dMode ? PH_SCAN : PH_DIRECT;
        mPtr   = 0;
      end else if (mPhase == PH_DIRECT) begin
        if (dMode) begin
          mPhase = PH_SCAN;
          mPtr   = 0;
          mValid = 1'b0;
        end else begin
          mCh    = dSel;
          mOut   = dIn[int'(dSel)*W +: W];
          mPar   = ^mOut;
          mValid = 1'b1;
        end
      end else begin
        if (!dMode) begin
          mPhase = PH_DIRECT;
          mValid = 1'b0;
        end else begin
          found = -1;
          for (int k = 0; k < CH; k++) begin
            if (found < 0 && dMask[(mPtr + k) % CH]) found = (mPtr + k) % CH;
          end
          if (found < 0) begin
            mValid = 1'b0;
          end else begin
            mCh    = 4'(found);
            mOut   = dIn[found*W +: W];
            mPar   = ^mOut;
            mValid = 1'b1;
            mPtr   = (found + 1) % CH;
          end
        end
      end
    end
  endtask

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".out"},       32'(dOut),   32'(mOut));
    checkValue({tag, ".out_ch"},    32'(dCh),    32'(mCh));
    checkValue({tag, ".out_valid"}, 32'(dValid), 32'(mValid));
`ifdef MUX_SCAN_PARITY_EN
    checkValue({tag, ".out_par"},   32'(dPar),   32'(mPar));
`endif
  endtask

  // Drive one cycle of inputs, advance the model on the edge, then compare
  // 1 time unit later.
  task automatic applyStimulus(input string tag, input logic r, input logic m,
                               input logic [3:0] s, input logic [15:0] mk,
                               input logic rd);
    rst    = r;
    dMode  = m;
    dSel   = s;
    dMask  = mk;
    dReady = rd;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput(tag);
  endtask

  initial begin
    logic        rMode;
    logic [15:0] rMask;
    int          expSeq [6];

    nChecks = 0;
    nFail   = 0;
    mPhase  = PH_IDLE;
    mOut    = '0;
    mCh     = '0;
    mValid  = 1'b0;
    mPtr    = 0;
    mPar    = 1'b0;

    rst    = 1'b1;
    dIn    = '0;
    dIn[5*W +: W] = 8'hA5;
    dIn[9*W +: W] = 8'h3C;
    dSel   = 4'd5;
    dMode  = 1'b0;
    dMask  = '0;
    dReady = 1'b1;
    cIn    = 12'h800;
    cSel   = 4'd14;
    cMode  = 1'b0;
    cMask  = '0;
    cReady = 1'b1;

    // Reset state
    applyStimulus("reset0", 1'b1, 1'b0, 4'd5, 16'h0000, 1'b1);
    applyStimulus("reset1", 1'b1, 1'b0, 4'd5, 16'h0000, 1'b1);
    checkValue("rst.valid", 32'(dValid), 32'd0);
    checkValue("rst.out",   32'(dOut),   32'd0);
    checkValue("rst.ch",    32'(dCh),    32'd0);
    checkValue("rst12.valid", 32'(cValid), 32'd0);

    // First load opportunity only leaves idle
    applyStimulus("idle2dir", 1'b0, 1'b0, 4'd5, 16'h0000, 1'b1);
    checkValue("idle2dir.valid", 32'(dValid), 32'd0);
    checkValue("idle12.valid",   32'(cValid), 32'd0);

    // Direct select, then clamp on the 12-channel instance
    applyStimulus("dir5", 1'b0, 1'b0, 4'd5, 16'h0000, 1'b1);
    checkValue("dir5.out",   32'(dOut),   32'hA5);
    checkValue("dir5.ch",    32'(dCh),    32'd5);
    checkValue("dir5.valid", 32'(dValid), 32'd1);
    checkValue("clamp14.out",   32'(cOut),   32'd1);
    checkValue("clamp14.ch",    32'(cCh),    32'd11);
    checkValue("clamp14.valid", 32'(cValid), 32'd1);

    cIn  = 12'hFF7;
    cSel = 4'd3;
    applyStimulus("dir9", 1'b0, 1'b0, 4'd9, 16'h0000, 1'b1);
    checkValue("dir9.out", 32'(dOut), 32'h3C);
    checkValue("dir9.ch",  32'(dCh),  32'd9);
    checkValue("sel3.out", 32'(cOut), 32'd0);
    checkValue("sel3.ch",  32'(cCh),  32'd3);

    cSel = 4'd15;
    applyStimulus("dir9b", 1'b0, 1'b0, 4'd9, 16'h0000, 1'b1);
    checkValue("clamp15.out", 32'(cOut), 32'd1);
    checkValue("clamp15.ch",  32'(cCh),  32'd11);

    // Scan wrap over mask 8421: one empty cycle for the mode switch
    applyStimulus("dir2scan", 1'b0, 1'b1, 4'd9, 16'h8421, 1'b1);
    checkValue("dir2scan.valid", 32'(dValid), 32'd0);
    expSeq = '{0, 5, 10, 15, 0, 5};
    for (int i = 0; i < 6; i++) begin
      applyStimulus("scan", 1'b0, 1'b1, 4'd0, 16'h8421, 1'b1);
      checkValue("scan.ch",    32'(dCh),    32'(expSeq[i]));
      checkValue("scan.valid", 32'(dValid), 32'd1);
    end

    // Backpressure: channel 5 (A5) held while data toggles
    for (int i = 0; i < 4; i++) begin
      dIn = {$urandom(), $urandom(), $urandom(), $urandom()};
      applyStimulus("stall", 1'b0, 1'b1, 4'd0, 16'h8421, 1'b0);
      checkValue("stall.ch",  32'(dCh),  32'd5);
      checkValue("stall.out", 32'(dOut), 32'hA5);
    end
    applyStimulus("resume", 1'b0, 1'b1, 4'd0, 16'h8421, 1'b1);
    checkValue("resume.ch", 32'(dCh), 32'd10);

    // Empty mask
    applyStimulus("mask0hold", 1'b0, 1'b1, 4'd0, 16'h0000, 1'b0);
    checkValue("mask0hold.valid", 32'(dValid), 32'd1);
    applyStimulus("mask0acc", 1'b0, 1'b1, 4'd0, 16'h0000, 1'b1);
    checkValue("mask0acc.valid", 32'(dValid), 32'd0);
    checkValue("mask0acc.ch",    32'(dCh),    32'd10);
    applyStimulus("mask0idle", 1'b0, 1'b1, 4'd0, 16'h0000, 1'b0);
    applyStimulus("mask4", 1'b0, 1'b1, 4'd0, 16'h0010, 1'b0);
    checkValue("mask4.ch",    32'(dCh),    32'd4);
    checkValue("mask4.valid", 32'(dValid), 32'd1);

    // Reset while a sample is stalled, then scanning restarts at channel 0
    dIn[0 +: W] = 8'hA5;
    applyStimulus("rstMid", 1'b1, 1'b1, 4'd0, 16'h8421, 1'b0);
    checkValue("rstMid.valid", 32'(dValid), 32'd0);
    checkValue("rstMid.out",   32'(dOut),   32'd0);
    checkValue("rstMid.ch",    32'(dCh),    32'd0);
`ifdef MUX_SCAN_PARITY_EN
    checkValue("rstMid.par",   32'(dPar),   32'd0);
`endif
    applyStimulus("idle2scan", 1'b0, 1'b1, 4'd0, 16'h8421, 1'b1);
    checkValue("idle2scan.valid", 32'(dValid), 32'd0);
    applyStimulus("scanRestart", 1'b0, 1'b1, 4'd0, 16'h8421, 1'b1);
    checkValue("scanRestart.ch",  32'(dCh),  32'd0);
    checkValue("scanRestart.out", 32'(dOut), 32'hA5);
`ifdef MUX_SCAN_PARITY_EN
    checkValue("scanRestart.par", 32'(dPar), 32'd0);
`endif

    // Randomised traffic against the model
    rMode = 1'b1;
    rMask = 16'h8421;
    for (int i = 0; i < 800; i++) begin
      dIn = {$urandom(), $urandom(), $urandom(), $urandom()};
      if ($urandom_range(0, 15) == 0) rMode = ~rMode;
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 3))
          0:       rMask = 16'h0000;
          1:       rMask = 16'(1) << $urandom_range(0, 15);
          default: rMask = 16'($urandom());
        endcase
      end
      applyStimulus("rand", 1'($urandom_range(0, 99) == 0), rMode,
                    4'($urandom()), rMask, 1'($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", nChecks - nFail, nChecks);
    $finish;
  end

endmodule

// File: doc/mux_scan.md
Name: mux_scan

Overview:
- Parametrised, registered N:1 channel selector.
- Successor to the team's fixed 16:1 combinational bit mux: generalised to CHANNELS channels of WIDTH bits each.
- Adds an output valid/ready handshake and an auto-scan mode that round-robins over a channel enable mask.
- Sits between a bank of sampled status/data lanes and a single serial consumer (logger or debug port).

Parameters:
- WIDTH, 1: data width per channel.
- CHANNELS, 16: number of input channels, legal range 2 to 256.
- SEL_W, $clog2(CHANNELS): select and channel-index width; derived, not for override.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in  input  CHANNELS*WIDTH  flattened channels; channel k = in[k*WIDTH +: WIDTH].
- sel  input  SEL_W  channel select, used in direct mode.
- mode  input  1  0 = direct, 1 = scan.
- mask  input  CHANNELS  per-channel enable, used in scan mode.
- out  output  WIDTH  registered selected data.
- out_ch  output  SEL_W  index of the channel held in out.
- out_valid  output  1  out/out_ch hold a sample.
- out_ready  input  1  consumer accepts the sample.

Behaviour:
- Reset (rst high at clk edge):
  - out=0, out_ch=0, out_valid=0, scan pointer ptr=0, state=S_IDLE.
  - rst overrides everything, including mid-handshake: out_valid is low after that edge.
- Load opportunity (LO) = !out_valid || out_ready.
  - Sample data is captured, not live.
  - While out_valid && !out_ready, out and out_ch are held stable regardless of in, sel, mode or mask.
- FSM states: S_IDLE, S_DIRECT, S_SCAN. The state is updated only on an LO.
  - S_IDLE: on the first LO after reset, go to S_DIRECT if mode=0, else S_SCAN (with ptr=0). No load occurs in this cycle.
  - S_DIRECT, on LO:
    - out <= channel sel.
    - If sel >= CHANNELS (non-power-of-2 CHANNELS), clamp to channel CHANNELS-1. This is the default-to-last-channel rule.
    - out_ch <= clamped index; out_valid <= 1.
    - If mode=1 at this LO, go to S_SCAN and set ptr=0 instead of loading.
  - S_SCAN, on LO:
    - Search for the first set mask bit at an index >= ptr. If none is found, wrap and search from index 0. The search is combinational and sequential in wrap order.
    - If found at index f: out <= channel f, out_ch <= f, out_valid <= 1, ptr <= f+1, or 0 when f = CHANNELS-1.
    - If mask is all-zero: out_valid <= 0, out and out_ch keep their last values, ptr unchanged.
    - If mode=0 at this LO, go to S_DIRECT without loading; out_valid <= 0.
- Latency and throughput:
  - Latency: 1 cycle from the LO edge to new data at out.
  - Throughput: 1 sample/cycle with out_ready held high.
  - A mode switch costs exactly one empty cycle.
- A single enabled channel in scan mode is reloaded on every LO.
- A mask change takes effect at the next LO and never affects a held sample.
- No combinational path from in, sel or mask to any output. out_ready affects only next-state logic.

Optional Feature:
- Macro: MUX_SCAN_PARITY_EN.
- Defined:
  - Adds output port out_par (1 bit): even parity (XOR reduction) of the captured channel data.
  - out_par is registered with out, cleared to 0 on reset, and held during stall.
- Undefined:
  - Port out_par does not exist; no parity logic.
  - All other behaviour is identical.

Test Plan:
- Direct select, WIDTH=8, CHANNELS=16, out_ready=1:
  - Stimulus: channel 5 = 8'hA5, mode=0, sel=5.
  - Response: out=8'hA5, out_ch=5, out_valid=1 one edge after the first LO from S_DIRECT.
  - Follow-up: change sel to 9 (channel 9 = 8'h3C) -> next cycle out=8'h3C.
- Clamp, CHANNELS=12, WIDTH=1:
  - Stimulus: sel=14, channel 11 = 1.
  - Response: out=1, out_ch=11.
- Scan wrap, CHANNELS=16, out_ready=1:
  - Stimulus: mask=16'h8421.
  - Response: out_ch sequence is 0, 5, 10, 15, 0, 5, ... with out_valid continuously 1.
- Backpressure:
  - Stimulus: in scan, hold out_ready=0 for 4 cycles while toggling channel data.
  - Response: out and out_ch stay constant. After out_ready=1 for one cycle, out_ch advances exactly one step.
- Empty mask:
  - Stimulus: mask=0 in scan.
  - Response: out_valid drops after the pending sample is accepted.
  - Follow-up: set mask=16'h0010 -> out_ch=4, out_valid=1 at the next edge.
- Reset mid-handshake:
  - Stimulus: assert rst for 1 cycle while out_valid=1 and out_ready=0.
  - Response: next edge out_valid=0, out=0, out_ch=0. Scanning restarts from channel 0.
  - Parity build only: out_par=0 after reset, then equals the XOR of a loaded 8'hA5 = 0.
